// File: rtl/uop_queue_pkg.sv
// uop_queue_pkg
//   Shared core definitions for the micro-op queue: uop width, the maximum
//   number of uops one instruction may expand to, the stored entry layout
//   {last, uop} and the uop_count clamp helper.
package uop_queue_pkg;

   localparam int unsigned UOP_W    = 20;
   localparam int unsigned MAX_UOPS = 3;

   typedef logic [UOP_W-1:0] uop_t;

   // Stored entry: bit UOP_W is the last flag, bits UOP_W-1:0 the uop.
   typedef struct packed {
      logic last;
      uop_t uop;
   } entry_t;

   // uop_count encodes extra uops beyond uop_0; 2'b11 is treated as 2'b10.
   function automatic logic [1:0] clamp_extra(input logic [1:0] cnt);
      return (cnt == 2'b11) ? 2'd2 : cnt;
   endfunction

endpackage

// File: rtl/uop_queue_if.sv
// uop_queue_if
//   Decode-side feed handshake and execute-side head handshake of the uop
//   queue.
//   slave  : the queue (accepts feed_ack/uops/uop_count/uop_ready, drives
//            feed_req/uop_valid/uop_out/uop_last).
//   master : the decode/execute side.
interface uop_queue_if
   import uop_queue_pkg::*;
();
   logic       feed_req;
   logic       feed_ack;
   uop_t       uop_0;
   uop_t       uop_1;
   uop_t       uop_2;
   logic [1:0] uop_count;
   logic       uop_valid;
   logic       uop_ready;
   uop_t       uop_out;
   logic       uop_last;

   modport slave (
      output feed_req, uop_valid, uop_out, uop_last,
      input  feed_ack, uop_0, uop_1, uop_2, uop_count, uop_ready
   );

   modport master (
      input  feed_req, uop_valid, uop_out, uop_last,
      output feed_ack, uop_0, uop_1, uop_2, uop_count, uop_ready
   );
endinterface

// File: rtl/uop_queue.sv
// uop_queue
//   Circular micro-op queue between decode and execute. One decoded
//   instruction (1..3 uops) is pushed per cycle; one uop is popped per cycle.
//   Ports:
//     clk       - clock, rising edge
//     a_rst     - asynchronous active-high reset
//     hold      - global stall, freezes push and pop
//     flush     - discard all queued uops
//     bus       - uop_queue_if.slave: feed_req/feed_ack/uop_0..2/uop_count,
//                 uop_valid/uop_ready/uop_out/uop_last
//     occupancy - current entry count
module uop_queue
   import uop_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   a_rst,
   input  logic                   hold,
   input  logic                   flush,
   uop_queue_if.slave             bus,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   entry_t     mem [DEPTH];
   ptr_t       head;
   ptr_t       tail;
   cnt_t       occ;

   logic       push;
   logic       pop;
   logic [1:0] extra;
   cnt_t       n_push;
   uop_t       in_uop [MAX_UOPS];
   logic       wr_en  [MAX_UOPS];
   entry_t     wr_ent [MAX_UOPS];

   assign occupancy = occ;

   always_comb begin
      in_uop[0] = bus.uop_0;
      in_uop[1] = bus.uop_1;
      in_uop[2] = bus.uop_2;
      extra     = clamp_extra(bus.uop_count);

      // Reset is included so feed_req stays low while a_rst is asserted.
      bus.feed_req  = ~a_rst & ~hold & ~flush &
                      ((cnt_t'(DEPTH) - occ) >= cnt_t'(MAX_UOPS));
      bus.uop_valid = (occ != '0) & ~flush;
      bus.uop_out   = mem[head].uop;
      bus.uop_last  = mem[head].last;

      push   = bus.feed_ack & bus.feed_req;
      pop    = bus.uop_valid & bus.uop_ready & ~hold;
      n_push = push ? (cnt_t'(extra) + cnt_t'(1)) : '0;

      // Slot tail+i receives uop_(extra-i): highest-numbered uop first,
      // uop_0 last and flagged as the instruction's final uop.
      for (int unsigned i = 0; i < MAX_UOPS; i++) begin
         wr_en[i]  = push & (2'(i) <= extra);
         wr_ent[i] = '0;
         if (2'(i) <= extra) begin
            wr_ent[i].last = (2'(i) == extra);
            wr_ent[i].uop  = in_uop[extra - 2'(i)];
         end
      end
   end

   // Storage is not reset; contents are only visible through uop_valid.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < MAX_UOPS; i++) begin
         if (wr_en[i]) begin
            mem[tail + ptr_t'(i)] <= wr_ent[i];
         end
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (pop) begin
            head <= head + ptr_t'(1);
         end
         if (push) begin
            tail <= tail + ptr_t'(n_push);
         end
         occ <= occ + n_push - cnt_t'(pop);
      end
   end

endmodule

// File: doc/uop_queue.md
UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning uop entries held; power of two, minimum 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port a_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port hold  input  1  global stall; freezes both push and pop.
REQ-005 SHALL have port flush  input  1  discard all queued uops (branch redirect, interrupt).
REQ-006 SHALL have port feed_req  output  1  queue can accept one full instruction.
REQ-007 SHALL have port feed_ack  input  1  decode issued an instruction this cycle.
REQ-008 SHALL have ports uop_0, uop_1, uop_2  input  20 each  decoded micro-ops.
REQ-009 SHALL have port uop_count  input  2  extra uops beyond uop_0 (0..2).
REQ-010 SHALL have port uop_valid  output  1  head entry valid toward execute.
REQ-011 SHALL have port uop_ready  input  1  execute consumes head this cycle.
REQ-012 SHALL have port uop_out  output  20  head micro-op.
REQ-013 SHALL have port uop_last  output  1  head is the final uop (uop_0) of its instruction.
REQ-014 SHALL have port occupancy  output  log2(DEPTH)+1  current entry count.

Function
REQ-015 SHALL store entries as {last, uop} 21 bits in a circular buffer with head/tail pointers and a separate occupancy counter.
REQ-016 SHALL drive feed_req = ~hold & ~flush & (DEPTH - occupancy >= 3).
REQ-017 SHALL push on edge when feed_ack & feed_req; feed_ack without feed_req is ignored.
REQ-018 SHALL push in order: count 2 -> uop_2, uop_1, uop_0; count 1 -> uop_1, uop_0; count 0 -> uop_0; all in one cycle into consecutive slots.
REQ-019 SHALL treat uop_count 2'b11 as 2'b10.
REQ-020 SHALL set last=1 only on the uop_0 entry of each push.
REQ-021 SHALL pop one entry on edge when uop_valid & uop_ready & ~hold.
REQ-022 SHALL drive uop_valid = (occupancy != 0) & ~flush; uop_out/uop_last from head slot combinationally.
REQ-023 SHALL have latency one cycle: uops pushed at edge N appear at head no earlier than after edge N; no same-cycle input-to-output bypass.
REQ-024 SHALL on simultaneous push and pop update occupancy by (pushed - 1) in one edge.
REQ-025 SHALL wrap pointers modulo DEPTH with no gap or duplicate at the wrap boundary.
REQ-026 SHALL on flush set head=tail=0 and occupancy=0 at the edge, overriding any push or pop in that cycle.
REQ-027 SHALL with hold high leave pointers, occupancy and storage unchanged regardless of feed_ack/uop_ready.
REQ-028 SHALL never exceed DEPTH entries; overflow impossible given REQ-016.

Reset
REQ-029 SHALL on a_rst high immediately clear head, tail, occupancy; outputs: uop_valid=0, feed_req=0 during reset, occupancy=0.
REQ-030 SHALL not reset storage array contents; uop_out is don't-care while uop_valid=0.
REQ-031 SHALL, if reset asserts mid-operation, drop all queued uops; first post-reset push lands in slot 0.

Structure
REQ-032 SHALL take uop width (20), max-uops-per-instruction (3) and uop field bit positions from the shared core package.
REQ-033 SHALL be a single module; the storage array is inline, no sub-module.

Verification
REQ-034 SHALL test: reset, push count=2 {uop_2=0x00003,uop_1=0x00002,uop_0=0x00001} with uop_ready=1 -> outputs 3,2,1 on three consecutive cycles, uop_last=0,0,1.
REQ-035 SHALL test: uop_ready=0, push count=2 twice (DEPTH=8, occupancy 6) -> feed_req=0; one pop -> occupancy 5, feed_req=1.
REQ-036 SHALL test: push count=0 every cycle with uop_ready=1 for 20 cycles -> occupancy stays at 1 after first cycle, uop_last=1 each, pointer wrap seen, order preserved.
REQ-037 SHALL test: occupancy 5, assert flush with feed_ack and uop_ready high -> next cycle occupancy=0, uop_valid=0, nothing pushed.
REQ-038 SHALL test: hold=1 for 3 cycles with feed_ack=1, uop_ready=1 -> occupancy and uop_out unchanged, feed_req=0.
REQ-039 SHALL test: uop_count=2'b11 -> exactly three entries pushed, as count 2.
